onehot_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single resource among N requesters using a rotating one-hot priority pointer. The pointer advances 001 → 010 → 100 and wraps back to 001. The block sits in front of a shared datapath and issues one-hot, registered grants with a request/done handshake. A hold-time limit stops any one requester from monopolising the resource, and a fixed turnaround gap separates consecutive owners.

---
 rtl/onehot_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_arbiter
// Purpose  : Round-robin arbiter with a rotating one-hot priority pointer.
//            Issues registered one-hot grants with a request/done handshake,
//            a hold-time limit that revokes long grants, and a fixed
//            two-cycle turnaround between consecutive owners.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1  rising-edge clock
//   reset    in   1  synchronous, active-high reset
//   req      in   N  level-sensitive request lines, bit i = requester i
//   done     in   N  release pulses; only the current owner's bit matters
//   grant    out  N  registered grant, one-hot or zero
//   busy     out  1  registered, equals |grant
//   timeout  out  1  registered one-cycle pulse on hold-limit revoke
//   ptr      out  N  registered one-hot priority pointer
// ============================================================================
module onehot_rr_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout,
  output logic [N-1:0] ptr
);

  // A zero limit still needs a legal (1-bit) counter.
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
  localparam logic [N-1:0]      ONE_N      = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [HOLD_W-1:0]   hold, hold_next;
  logic [N-1:0]        grant_next;
  logic [N-1:0]        ptr_next;
  logic                timeout_next;

  logic [N-1:0]        below_ptr;
  logic [N-1:0]        masked_req;
  logic [N-1:0]        pick_masked;
  logic [N-1:0]        pick_any;
  logic [N-1:0]        pick;
  logic [N-1:0]        owner_rot;
  logic                owner_done;
  logic                owner_req;
  logic                hold_hit;

  // Requests at or above the pointer take precedence; if none, the lowest
  // request overall wins, which is the wrap from MSB back to LSB.
  // x & (~x + 1) isolates the lowest set bit.
  assign below_ptr   = ptr - ONE_N;
  assign masked_req  = req & ~below_ptr;
  assign pick_masked = masked_req & (~masked_req + ONE_N);
  assign pick_any    = req & (~req + ONE_N);
  assign pick        = (|masked_req) ? pick_masked : pick_any;

  generate
    if (N == 1) begin : g_rot_single
      assign owner_rot = grant;
    end else begin : g_rot_multi
      assign owner_rot = {grant[N-2:0], grant[N-1]};
    end
  endgenerate

  // grant is one-hot in GRANT, so masking selects the owner's bit.
  assign owner_done = |(grant & done);
  assign owner_req  = |(grant & req);
  assign hold_hit   = (MAX_HOLD != 0) && (hold == HOLD_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= ONE_N;
      hold    <= '0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      busy    <= |grant_next;
      timeout <= timeout_next;
      ptr     <= ptr_next;
      hold    <= hold_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    ptr_next     = ptr;
    hold_next    = hold;
    timeout_next = 1'b0;

    unique case (state)
      IDLE: begin
        grant_next = '0;
        if (|req) begin
          grant_next = pick;
          hold_next  = HOLD_W'(1);
          state_next = GRANT;
        end
      end

      GRANT: begin
        // Voluntary release outranks the hold limit, so a done on the
        // limit cycle never raises timeout.
        if (owner_done || !owner_req) begin
          grant_next = '0;
          ptr_next   = owner_rot;
          state_next = GAP;
        end else if (hold_hit) begin
          grant_next   = '0;
          ptr_next     = owner_rot;
          timeout_next = 1'b1;
          state_next   = GAP;
        end else if (hold != HOLD_SAT) begin
          hold_next = hold + HOLD_W'(1);
        end
      end

      GAP: begin
        grant_next = '0;
        state_next = IDLE;
      end

      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_rr_arbiter
// Purpose  : Self-checking bench for onehot_rr_arbiter. Two instances share
//            stimulus: one with MAX_HOLD = 8, one with the limit disabled.
//            A behavioural model predicts every cycle's outputs; predictions
//            are queued when stimulus is driven and compared after the edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_onehot_rr_arbiter;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;

  logic [N-1:0] grant_a, ptr_a;
  logic         busy_a, tmo_a;
  logic [N-1:0] grant_b, ptr_b;
  logic         busy_b, tmo_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut_a (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant_a), .busy(busy_a), .timeout(tmo_a), .ptr(ptr_a)
  );

  onehot_rr_arbiter #(.N(N), .MAX_HOLD(0)) dut_b (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant_b), .busy(busy_b), .timeout(tmo_b), .ptr(ptr_b)
  );

  typedef struct {
    int st;      // 0 idle, 1 grant, 2 gap
    int owner;
    int pidx;
    int hold;
    bit tmo;
  } mstate_t;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         busy;
    logic         tmo;
    logic [N-1:0] ptr;
  } exp_t;

  mstate_t ma, mb;
  exp_t    q_a[$];
  exp_t    q_b[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t model_step(input mstate_t s, input logic [N-1:0] rq,
                                         input logic [N-1:0] dn, input bit rst, input int maxh);
    mstate_t n;
    bit      found;
    int      idx;
    n = s;
    n.tmo = 1'b0;
    if (rst) begin
      n.st = 0; n.owner = 0; n.pidx = 0; n.hold = 0;
      return n;
    end
    case (s.st)
      0: begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (s.pidx + k) % N;
          if (!found && rq[idx]) begin
            found   = 1'b1;
            n.owner = idx;
          end
        end
        if (found) begin
          n.st = 1; n.hold = 1;
        end
      end
      1: begin
        if (dn[s.owner] || !rq[s.owner]) begin
          n.st = 2; n.pidx = (s.owner + 1) % N;
        end else if (maxh != 0 && s.hold == maxh) begin
          n.st = 2; n.pidx = (s.owner + 1) % N; n.tmo = 1'b1;
        end else begin
          n.hold = s.hold + 1;
        end
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic exp_t expect_of(input mstate_t s);
    exp_t e;
    e.grant = (s.st == 1) ? (N'(1) << s.owner) : '0;
    e.busy  = (s.st == 1);
    e.tmo   = s.tmo;
    e.ptr   = N'(1) << s.pidx;
    return e;
  endfunction

  // One clock: drive inputs, queue the prediction, then compare after the edge.
  task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] dn, input bit rst);
    exp_t e;
    @(negedge clk);
    req = rq; done = dn; reset = rst;
    ma = model_step(ma, rq, dn, rst, 8);
    mb = model_step(mb, rq, dn, rst, 0);
    q_a.push_back(expect_of(ma));
    q_b.push_back(expect_of(mb));
    @(posedge clk);
    #1;
    e = q_a.pop_front();
    check_eq("a_grant", 32'(grant_a), 32'(e.grant));
    check_eq("a_busy",  32'(busy_a),  32'(e.busy));
    check_eq("a_tmo",   32'(tmo_a),   32'(e.tmo));
    check_eq("a_ptr",   32'(ptr_a),   32'(e.ptr));
    e = q_b.pop_front();
    check_eq("b_grant", 32'(grant_b), 32'(e.grant));
    check_eq("b_busy",  32'(busy_b),  32'(e.busy));
    check_eq("b_tmo",   32'(tmo_b),   32'(e.tmo));
    check_eq("b_ptr",   32'(ptr_b),   32'(e.ptr));
  endtask

  task automatic do_reset();
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rot_own [4];
    logic [N-1:0] rot_ptr [4];
    logic [N-1:0] rq, dn;
    rot_own = '{3'b001, 3'b010, 3'b100, 3'b001};
    rot_ptr = '{3'b010, 3'b100, 3'b001, 3'b010};
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset values
    do_reset();
    check_eq("rst_grant", 32'(grant_a), 32'h0);
    check_eq("rst_busy",  32'(busy_a),  32'h0);
    check_eq("rst_tmo",   32'(tmo_a),   32'h0);
    check_eq("rst_ptr",   32'(ptr_a),   32'h1);

    // Rotation: each owner releases on its 2nd grant cycle
    for (int i = 0; i < 4; i++) begin
      cycle(3'b111, 3'b000, 1'b0);
      check_eq("rot_g1", 32'(grant_a), 32'(rot_own[i]));
      cycle(3'b111, 3'b000, 1'b0);
      check_eq("rot_g2", 32'(grant_a), 32'(rot_own[i]));
      cycle(3'b111, rot_own[i], 1'b0);
      check_eq("rot_gap", 32'(grant_a), 32'h0);
      check_eq("rot_ptr", 32'(ptr_a), 32'(rot_ptr[i]));
      cycle(3'b111, 3'b000, 1'b0);
      check_eq("rot_idle", 32'(grant_a), 32'h0);
    end

    // Wrap with a single requester
    do_reset();
    cycle(3'b100, 3'b000, 1'b0);
    check_eq("wrap_g", 32'(grant_a), 32'h4);
    cycle(3'b100, 3'b100, 1'b0);
    check_eq("wrap_rel", 32'(grant_a), 32'h0);
    check_eq("wrap_ptr", 32'(ptr_a), 32'h1);
    cycle(3'b100, 3'b000, 1'b0);
    cycle(3'b100, 3'b000, 1'b0);
    check_eq("wrap_regrant", 32'(grant_a), 32'h4);
    cycle(3'b000, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 1'b0);

    // Timeout: limit 8 on dut_a, unlimited on dut_b
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cycle(3'b010, 3'b000, 1'b0);
      check_eq("to_hold", 32'(grant_a), 32'h2);
      check_eq("to_hold_tmo", 32'(tmo_a), 32'h0);
      check_eq("nolim_hold", 32'(grant_b), 32'h2);
    end
    cycle(3'b010, 3'b000, 1'b0);
    check_eq("to_drop", 32'(grant_a), 32'h0);
    check_eq("to_pulse", 32'(tmo_a), 32'h1);
    check_eq("to_busy", 32'(busy_a), 32'h0);
    check_eq("to_ptr", 32'(ptr_a), 32'h4);
    check_eq("nolim_keep", 32'(grant_b), 32'h2);
    cycle(3'b010, 3'b000, 1'b0);
    check_eq("to_pulse_end", 32'(tmo_a), 32'h0);
    check_eq("to_gap2", 32'(grant_a), 32'h0);
    cycle(3'b010, 3'b000, 1'b0);
    check_eq("to_regrant", 32'(grant_a), 32'h2);
    for (int k = 0; k < 12; k++) begin
      cycle(3'b010, 3'b000, 1'b0);
      check_eq("nolim_long", 32'(grant_b), 32'h2);
      check_eq("nolim_tmo", 32'(tmo_b), 32'h0);
    end

    // Foreign done and req drop
    do_reset();
    cycle(3'b001, 3'b000, 1'b0);
    check_eq("fd_g", 32'(grant_a), 32'h1);
    cycle(3'b001, 3'b110, 1'b0);
    check_eq("fd_ign1", 32'(grant_a), 32'h1);
    cycle(3'b001, 3'b110, 1'b0);
    check_eq("fd_ign2", 32'(grant_a), 32'h1);
    cycle(3'b000, 3'b000, 1'b0);
    check_eq("fd_drop", 32'(grant_a), 32'h0);
    check_eq("fd_tmo", 32'(tmo_a), 32'h0);
    cycle(3'b000, 3'b000, 1'b0);

    // Done on the same cycle the limit is reached
    do_reset();
    for (int k = 1; k <= 8; k++) cycle(3'b001, 3'b000, 1'b0);
    check_eq("sim_pre", 32'(grant_a), 32'h1);
    cycle(3'b001, 3'b001, 1'b0);
    check_eq("sim_rel", 32'(grant_a), 32'h0);
    check_eq("sim_tmo", 32'(tmo_a), 32'h0);
    cycle(3'b000, 3'b000, 1'b0);

    // Reset mid-grant with grant = 100 and ptr = 100
    do_reset();
    cycle(3'b010, 3'b000, 1'b0);
    cycle(3'b010, 3'b010, 1'b0);
    cycle(3'b000, 3'b000, 1'b0);
    cycle(3'b100, 3'b000, 1'b0);
    check_eq("mr_pre_g", 32'(grant_a), 32'h4);
    check_eq("mr_pre_p", 32'(ptr_a), 32'h4);
    cycle(3'b111, 3'b100, 1'b1);
    check_eq("mr_grant", 32'(grant_a), 32'h0);
    check_eq("mr_ptr", 32'(ptr_a), 32'h1);
    check_eq("mr_busy", 32'(busy_a), 32'h0);
    cycle(3'b111, 3'b000, 1'b0);
    check_eq("mr_first", 32'(grant_a), 32'h1);

    // Random traffic checked against the model
    for (int k = 0; k < 300; k++) begin
      rq = N'($urandom_range(0, 7));
      dn = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 7)) : '0;
      cycle(rq, dn, ($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
